fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous packet FIFO (the 4-entry packet_t FIFO) among NREQ producer ports. Each producer presents a packet_t with a valid/ready handshake. The arbiter selects one producer per cycle, drives the FIFO's writep/din, and honours fullp so that no write is ever lost. A producer may lock the grant for a burst of consecutive packets, bounded by BURST_MAX.

---
 rtl/fifo_write_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter sharing one packet FIFO among NREQ producers,
// with optional per-producer burst locking bounded by BURST_MAX.
package fifo_write_arbiter_pkg;
  typedef struct packed {
    logic [7:0]      src;
    logic [7:0]      dst;
    logic [0:3][7:0] data;
  } packet_t;
endpackage

module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  packet_t [NREQ-1:0]     req_pkt,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_fullp,
  output logic                   fifo_writep,
  output packet_t                fifo_din,
  output logic [IW-1:0]          grant_id,
  output logic                   locked,
  output logic [15:0]            accept_cnt
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [IW-1:0] owner, owner_nx;
  logic [3:0]    burst_cnt, burst_cnt_nx;
  logic [IW-1:0] scan_id;
  logic [IW:0]   cand;
  logic          found;
  logic [3:0]    burst_inc;
  logic          xfer;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // First valid port scanning upward from rr_ptr; falls back to rr_ptr.
  always_comb begin
    scan_id = rr_ptr;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        scan_id = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    grant_id    = (state == LOCKED) ? owner : scan_id;
    locked      = (state == LOCKED);
    fifo_din    = req_pkt[grant_id];
    fifo_writep = rstn && req_valid[grant_id] && !fifo_fullp;
    req_ready   = '0;
    if (rstn && !fifo_fullp) req_ready[grant_id] = 1'b1;
  end

  assign xfer      = fifo_writep;
  assign burst_inc = burst_cnt + 4'd1;

  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    owner_nx     = owner;
    burst_cnt_nx = burst_cnt;
    unique case (state)
      ARB: begin
        if (xfer) begin
          if (req_lock[grant_id] && BURST_MAX > 1) begin
            state_nx     = LOCKED;
            owner_nx     = grant_id;
            burst_cnt_nx = 4'd1;
          end else begin
            rr_ptr_nx = wrap_inc(grant_id);
          end
        end
      end
      LOCKED: begin
        // A full-stalled cycle has no transfer, so it never advances burst_cnt.
        if (xfer) begin
          burst_cnt_nx = burst_inc;
          if (burst_inc == 4'(BURST_MAX) || !req_lock[owner]) begin
            state_nx  = ARB;
            rr_ptr_nx = wrap_inc(owner);
          end
        end else if (!req_lock[owner]) begin
          state_nx  = ARB;
          rr_ptr_nx = wrap_inc(owner);
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB;
      rr_ptr     <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      accept_cnt <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      owner     <= owner_nx;
      burst_cnt <= burst_cnt_nx;
      if (xfer) accept_cnt <= accept_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NREQ=4, BURST_MAX=4).
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  logic              clk;
  logic              rstn;
  logic [3:0]        req_valid;
  packet_t [3:0]     req_pkt;
  logic [3:0]        req_lock;
  logic [3:0]        req_ready;
  logic              fifo_fullp;
  logic              fifo_writep;
  packet_t           fifo_din;
  logic [1:0]        grant_id;
  logic              locked;
  logic [15:0]       accept_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;

  fifo_write_arbiter #(.NREQ(4), .BURST_MAX(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_pkt    (req_pkt),
    .req_lock   (req_lock),
    .req_ready  (req_ready),
    .fifo_fullp (fifo_fullp),
    .fifo_writep(fifo_writep),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .locked     (locked),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic packet_t mk(input int unsigned i);
    packet_t p;
    p.src = 8'(i);
    p.dst = 8'(8'h40 + i);
    for (int unsigned k = 0; k < 4; k++) p.data[k] = 8'(16 * i + k + 1);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn       = 1'b0;
    req_valid  = 4'b1111;
    req_lock   = '0;
    fifo_fullp = 1'b0;
    for (int unsigned i = 0; i < 4; i++) req_pkt[i] = mk(i);

    // Reset state, with all ports valid: handshake outputs gated off
    #3;
    chk("rst_writep", 64'(fifo_writep), 64'd0);
    chk("rst_ready",  64'(req_ready),   64'd0);
    chk("rst_accept", 64'(accept_cnt),  64'd0);
    chk("rst_locked", 64'(locked),      64'd0);
    chk("rst_grant",  64'(grant_id),    64'd0);
    tick();
    rstn = 1'b1;

    // Round robin: 0,1,2,3,0
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rr_grant",  64'(grant_id),     64'(c % 4));
      chk("rr_writep", 64'(fifo_writep),  64'd1);
      chk("rr_src",    64'(fifo_din.src), 64'(c % 4));
      chk("rr_ready",  64'(req_ready),    64'(4'b0001 << (c % 4)));
      tick();
    end
    chk("rr_accept", 64'(accept_cnt), 64'd5);

    // Burst lock on port 2 (rr_ptr=1, port 1 idle so port 2 wins)
    req_valid = 4'b1101;
    req_lock  = 4'b0100;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("burst_grant",  64'(grant_id),    64'd2);
      chk("burst_writep", 64'(fifo_writep), 64'd1);
      chk("burst_locked", 64'(locked),      64'(c != 0));
      tick();
    end
    @(negedge clk);
    chk("burst_next_grant",  64'(grant_id), 64'd3);
    chk("burst_next_locked", 64'(locked),   64'd0);
    tick();
    chk("burst_accept", 64'(accept_cnt), 64'd10);
    req_lock = '0;

    // Full stall with port 1 valid (rr_ptr=0)
    req_valid  = 4'b0010;
    fifo_fullp = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_writep", 64'(fifo_writep), 64'd0);
      chk("stall_ready",  64'(req_ready),   64'd0);
      tick();
    end
    chk("stall_accept_hold", 64'(accept_cnt), 64'd10);
    fifo_fullp = 1'b0;
    @(negedge clk);
    chk("unstall_writep", 64'(fifo_writep), 64'd1);
    chk("unstall_din",    64'(fifo_din),    64'(mk(1)));
    chk("unstall_ready",  64'(req_ready),   64'd2);
    tick();
    chk("unstall_accept", 64'(accept_cnt), 64'd11);
    req_valid = '0;
    @(negedge clk);
    chk("unstall_single", 64'(fifo_writep), 64'd0);
    tick();

    // Lock on port 0, then release while full (rr_ptr=2)
    req_valid = 4'b0001;
    req_lock  = 4'b0001;
    tick();
    chk("lockfull_locked", 64'(locked), 64'd1);
    fifo_fullp = 1'b1;
    tick();
    chk("lockfull_held",  64'(locked),      64'd1);
    chk("lockfull_nowr",  64'(fifo_writep), 64'd0);
    req_lock  = '0;
    tick();
    chk("release_locked", 64'(locked),      64'd0);
    req_valid = '0;
    #1;
    chk("release_rrptr",  64'(grant_id),    64'd1);
    chk("release_nowr",   64'(fifo_writep), 64'd0);
    chk("release_accept", 64'(accept_cnt),  64'd12);
    fifo_fullp = 1'b0;

    // Async reset mid-burst on port 3
    req_valid = 4'b1000;
    req_lock  = 4'b1000;
    tick();
    chk("midrst_locked_pre", 64'(locked), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_locked", 64'(locked),      64'd0);
    chk("midrst_writep", 64'(fifo_writep), 64'd0);
    chk("midrst_accept", 64'(accept_cnt),  64'd0);
    req_valid = 4'b1010;
    req_lock  = '0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_grant",  64'(grant_id),    64'd1);
    chk("postrst_writep", 64'(fifo_writep), 64'd1);
    tick();
    chk("postrst_accept", 64'(accept_cnt), 64'd1);

    // Counter wrap: fill to 0xFFFE, then three more writes
    req_valid = 4'b1111;
    repeat (65533) @(posedge clk);
    #1;
    chk("wrap_preload", 64'(accept_cnt), 64'hFFFE);
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wrap_writep", 64'(fifo_writep), 64'd1);
      tick();
    end
    chk("wrap_accept", 64'(accept_cnt), 64'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
